// File: rtl/glcd_pkg.sv
`default_nettype none
// ============================================================================
// glcd_pkg : KS0108 opcodes and controller state encoding
// Rev 1.0
// ============================================================================
package glcd_pkg;

    localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
    localparam logic [7:0] CMD_START_LINE = 8'hC0;
    localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
    localparam logic [7:0] CMD_SET_COL    = 8'h40;

    typedef enum logic [3:0] {
        ST_PWR_RST  = 4'd0,
        ST_PWR_WAIT = 4'd1,
        ST_INIT     = 4'd2,
        ST_CLEAR    = 4'd3,
        ST_IDLE     = 4'd4,
        ST_ERR      = 4'd5,
        ST_SET_PAGE = 4'd6,
        ST_SET_COL  = 4'd7,
        ST_WRITE    = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/glcd_bus_cycle.sv
`default_nettype none
// ============================================================================
// glcd_bus_cycle : one panel bus cycle with setup / E-high / hold timing
// Rev 1.0
// ============================================================================
module glcd_bus_cycle #(
    parameter int N_CHIPS = 2,
    parameter int T_SU    = 2,
    parameter int T_EH    = 8,
    parameter int T_EL    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_CHIPS-1:0] cs_in,
    input  logic               rs_in,
    input  logic [7:0]         data_in,
    output logic               done,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic [7:0]         lcd_data,
    output logic [N_CHIPS-1:0] lcd_cs
);

    localparam int TOTAL = T_SU + T_EH + T_EL;
    localparam int CW    = $clog2(TOTAL + 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;

    // Done fires during the last clock so the next cycle can start one idle clock later.
    assign done = r_busy && (r_cnt == CW'(TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            lcd_cs   <= '0;
        end else if (!r_busy) begin
            if (start) begin
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                lcd_e    <= 1'b0;
                lcd_rs   <= rs_in;
                lcd_data <= data_in;
                lcd_cs   <= cs_in;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(T_SU - 1))
                lcd_e <= 1'b1;
            if (r_cnt == CW'(T_SU + T_EH - 1))
                lcd_e <= 1'b0;
            if (r_cnt == CW'(TOTAL - 1)) begin
                r_busy   <= 1'b0;
                lcd_rs   <= 1'b0;
                lcd_data <= 8'h00;
                lcd_cs   <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/glcd_pixel_writer.sv
`default_nettype none
// ============================================================================
// glcd_pixel_writer : KS0108-class panel init/clear and cached byte writer
// Rev 1.0
// ============================================================================
module glcd_pixel_writer
    import glcd_pkg::*;
#(
    parameter int N_CHIPS       = 2,
    parameter int COLS_PER_CHIP = 64,
    parameter int PAGES         = 8,
    parameter int T_SU          = 2,
    parameter int T_EH          = 8,
    parameter int T_EL          = 8,
    parameter int PWRUP_CYCLES  = 1000,
    parameter int CLEAR_ON_INIT = 1,
    localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int COL_W  = $clog2(N_CHIPS * COLS_PER_CHIP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [PAGE_W-1:0]  wr_page,
    input  logic [COL_W-1:0]   wr_col,
    input  logic [7:0]         wr_data,
    output logic               wr_err,
    output logic               init_done,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic [7:0]         lcd_data,
    output logic [N_CHIPS-1:0] lcd_cs,
    output logic               lcd_reset
);

    localparam int CB     = $clog2(COLS_PER_CHIP);
    localparam int CHIP_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam int WAIT_W = $clog2(PWRUP_CYCLES + 1);
    localparam logic [COL_W:0]  C_NCOLS = (COL_W + 1)'(N_CHIPS * COLS_PER_CHIP);
    localparam logic [PAGE_W:0] C_PAGES = (PAGE_W + 1)'(PAGES);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic [CHIP_W-1:0]   r_chip;
    logic [PAGE_W-1:0]   r_page;
    logic [CB-1:0]       r_lcol;
    logic [7:0]          r_wdata;
    logic                r_step;
    logic [1:0]          r_clr_phase;
    logic [PAGE_W-1:0]   r_clr_page;
    logic [CB-1:0]       r_clr_col;

    logic                r_start;
    logic [N_CHIPS-1:0]  r_bus_cs;
    logic                r_bus_rs;
    logic [7:0]          r_bus_data;

    logic [N_CHIPS-1:0]  r_cpv;
    logic [N_CHIPS-1:0]  r_ccv;
    logic [PAGE_W-1:0]   r_cpage [N_CHIPS];
    logic [CB-1:0]       r_ccol  [N_CHIPS];

    logic                w_done;
    logic [CHIP_W-1:0]   w_acc_chip;
    logic [CB-1:0]       w_acc_lcol;
    logic                w_in_range;
    logic                w_hit_page;
    logic                w_hit_col;
    logic                w_cur_hit_col;

    assign lcd_rw        = 1'b0;
    assign w_acc_chip    = CHIP_W'(wr_col >> CB);
    assign w_acc_lcol    = wr_col[CB-1:0];
    assign w_in_range    = ({1'b0, wr_col} < C_NCOLS) && ({1'b0, wr_page} < C_PAGES);
    assign w_hit_page    = r_cpv[w_acc_chip] && (r_cpage[w_acc_chip] == wr_page);
    assign w_hit_col     = r_ccv[w_acc_chip] && (r_ccol[w_acc_chip] == w_acc_lcol);
    assign w_cur_hit_col = r_ccv[r_chip] && (r_ccol[r_chip] == r_lcol);

    task automatic issue(input logic [CHIP_W-1:0] chip, input logic rs, input logic [7:0] data);
        r_start    <= 1'b1;
        r_bus_cs   <= N_CHIPS'(1) << chip;
        r_bus_rs   <= rs;
        r_bus_data <= data;
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_PWR_RST;
            r_wait      <= '0;
            r_chip      <= '0;
            r_page      <= '0;
            r_lcol      <= '0;
            r_wdata     <= 8'h00;
            r_step      <= 1'b0;
            r_clr_phase <= 2'd0;
            r_clr_page  <= '0;
            r_clr_col   <= '0;
            r_start     <= 1'b0;
            r_bus_cs    <= '0;
            r_bus_rs    <= 1'b0;
            r_bus_data  <= 8'h00;
            r_cpv       <= '0;
            r_ccv       <= '0;
            for (int i = 0; i < N_CHIPS; i++) begin
                r_cpage[i] <= '0;
                r_ccol[i]  <= '0;
            end
            wr_ready    <= 1'b0;
            wr_err      <= 1'b0;
            init_done   <= 1'b0;
            lcd_reset   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            wr_err  <= 1'b0;
            case (r_state)
                ST_PWR_RST: begin
                    if (r_wait == WAIT_W'(PWRUP_CYCLES - 1)) begin
                        r_wait    <= '0;
                        lcd_reset <= 1'b1;
                        r_state   <= ST_PWR_WAIT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_PWR_WAIT: begin
                    if (r_wait == WAIT_W'(PWRUP_CYCLES - 1)) begin
                        r_wait  <= '0;
                        r_chip  <= '0;
                        r_step  <= 1'b0;
                        issue('0, 1'b0, CMD_DISP_ON);
                        r_state <= ST_INIT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (w_done) begin
                        if (!r_step) begin
                            r_step <= 1'b1;
                            issue(r_chip, 1'b0, CMD_START_LINE);
                        end else if (r_chip != CHIP_W'(N_CHIPS - 1)) begin
                            r_chip <= r_chip + 1'b1;
                            r_step <= 1'b0;
                            issue(r_chip + 1'b1, 1'b0, CMD_DISP_ON);
                        end else if (CLEAR_ON_INIT != 0) begin
                            r_chip      <= '0;
                            r_clr_page  <= '0;
                            r_clr_phase <= 2'd0;
                            issue('0, 1'b0, CMD_SET_PAGE);
                            r_state     <= ST_CLEAR;
                        end else begin
                            init_done <= 1'b1;
                            wr_ready  <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (w_done) begin
                        case (r_clr_phase)
                            2'd0: begin
                                r_clr_phase <= 2'd1;
                                issue(r_chip, 1'b0, CMD_SET_COL);
                            end
                            2'd1: begin
                                r_clr_phase <= 2'd2;
                                r_clr_col   <= '0;
                                issue(r_chip, 1'b1, 8'h00);
                            end
                            default: begin
                                if (r_clr_col != CB'(COLS_PER_CHIP - 1)) begin
                                    r_clr_col <= r_clr_col + 1'b1;
                                    issue(r_chip, 1'b1, 8'h00);
                                end else if (r_clr_page != PAGE_W'(PAGES - 1)) begin
                                    r_clr_page  <= r_clr_page + 1'b1;
                                    r_clr_phase <= 2'd0;
                                    issue(r_chip, 1'b0, CMD_SET_PAGE | 8'(r_clr_page + 1'b1));
                                end else if (r_chip != CHIP_W'(N_CHIPS - 1)) begin
                                    r_chip      <= r_chip + 1'b1;
                                    r_clr_page  <= '0;
                                    r_clr_phase <= 2'd0;
                                    issue(r_chip + 1'b1, 1'b0, CMD_SET_PAGE);
                                end else begin
                                    // Panel auto-increment has wrapped every chip back to column 0.
                                    r_cpv <= '1;
                                    r_ccv <= '1;
                                    for (int i = 0; i < N_CHIPS; i++) begin
                                        r_cpage[i] <= PAGE_W'(PAGES - 1);
                                        r_ccol[i]  <= '0;
                                    end
                                    init_done <= 1'b1;
                                    wr_ready  <= 1'b1;
                                    r_state   <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end
                ST_IDLE: begin
                    if (wr_valid && wr_ready) begin
                        wr_ready <= 1'b0;
                        if (!w_in_range) begin
                            wr_err  <= 1'b1;
                            r_state <= ST_ERR;
                        end else begin
                            r_chip  <= w_acc_chip;
                            r_page  <= wr_page;
                            r_lcol  <= w_acc_lcol;
                            r_wdata <= wr_data;
                            if (!w_hit_page) begin
                                issue(w_acc_chip, 1'b0, CMD_SET_PAGE | 8'(wr_page));
                                r_state <= ST_SET_PAGE;
                            end else if (!w_hit_col) begin
                                issue(w_acc_chip, 1'b0, CMD_SET_COL | 8'(w_acc_lcol));
                                r_state <= ST_SET_COL;
                            end else begin
                                issue(w_acc_chip, 1'b1, wr_data);
                                r_state <= ST_WRITE;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    wr_ready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                ST_SET_PAGE: begin
                    if (w_done) begin
                        r_cpv[r_chip]   <= 1'b1;
                        r_cpage[r_chip] <= r_page;
                        if (w_cur_hit_col) begin
                            issue(r_chip, 1'b1, r_wdata);
                            r_state <= ST_WRITE;
                        end else begin
                            issue(r_chip, 1'b0, CMD_SET_COL | 8'(r_lcol));
                            r_state <= ST_SET_COL;
                        end
                    end
                end
                ST_SET_COL: begin
                    if (w_done) begin
                        r_ccv[r_chip]  <= 1'b1;
                        r_ccol[r_chip] <= r_lcol;
                        issue(r_chip, 1'b1, r_wdata);
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_done) begin
                        r_ccv[r_chip]  <= 1'b1;
                        r_ccol[r_chip] <= r_lcol + 1'b1;
                        wr_ready       <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_PWR_RST;
            endcase
        end
    end

    glcd_bus_cycle #(
        .N_CHIPS (N_CHIPS),
        .T_SU    (T_SU),
        .T_EH    (T_EH),
        .T_EL    (T_EL)
    ) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (r_start),
        .cs_in    (r_bus_cs),
        .rs_in    (r_bus_rs),
        .data_in  (r_bus_data),
        .done     (w_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .lcd_cs   (lcd_cs)
    );

endmodule
`default_nettype wire

// File: tb/tb_glcd_pixel_writer.sv
`default_nettype none
// ============================================================================
// tb_glcd_pixel_writer : directed vector bench for glcd_pixel_writer
// Rev 1.0
// ============================================================================
module tb_glcd_pixel_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_n_c;

    // main DUT: 2 chips, no clear
    logic       wr_valid, wr_ready, wr_err, init_done;
    logic [2:0] wr_page;
    logic [6:0] wr_col;
    logic [7:0] wr_data;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_reset;
    logic [7:0] lcd_data;
    logic [1:0] lcd_cs;

    // range-check DUT: 3 chips, 6 pages
    logic       ev, e_wr_ready, e_wr_err, e_init_done;
    logic [2:0] epage;
    logic [7:0] ecol;
    logic       e_lcd_e, e_lcd_rs, e_lcd_rw, e_lcd_reset;
    logic [7:0] e_lcd_data;
    logic [2:0] e_lcd_cs;

    // clear DUT: 2 chips, clear on init
    logic       cv, c_wr_ready, c_wr_err, c_init_done;
    logic       c_lcd_e, c_lcd_rs, c_lcd_rw, c_lcd_reset;
    logic [7:0] c_lcd_data;
    logic [1:0] c_lcd_cs;

    glcd_pixel_writer #(.N_CHIPS(2), .COLS_PER_CHIP(64), .PAGES(8), .T_SU(1), .T_EH(2), .T_EL(2),
                        .PWRUP_CYCLES(4), .CLEAR_ON_INIT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_page(wr_page),
        .wr_col(wr_col), .wr_data(wr_data), .wr_err(wr_err), .init_done(init_done), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .lcd_cs(lcd_cs), .lcd_reset(lcd_reset));

    glcd_pixel_writer #(.N_CHIPS(3), .COLS_PER_CHIP(64), .PAGES(6), .T_SU(1), .T_EH(2), .T_EL(2),
                        .PWRUP_CYCLES(4), .CLEAR_ON_INIT(0)) u_err (
        .clk(clk), .rst_n(rst_n), .wr_valid(ev), .wr_ready(e_wr_ready), .wr_page(epage),
        .wr_col(ecol), .wr_data(8'h5A), .wr_err(e_wr_err), .init_done(e_init_done), .lcd_e(e_lcd_e),
        .lcd_rs(e_lcd_rs), .lcd_rw(e_lcd_rw), .lcd_data(e_lcd_data), .lcd_cs(e_lcd_cs), .lcd_reset(e_lcd_reset));

    glcd_pixel_writer #(.N_CHIPS(2), .COLS_PER_CHIP(64), .PAGES(8), .T_SU(1), .T_EH(2), .T_EL(2),
                        .PWRUP_CYCLES(4), .CLEAR_ON_INIT(1)) u_clr (
        .clk(clk), .rst_n(rst_n_c), .wr_valid(cv), .wr_ready(c_wr_ready), .wr_page(wr_page),
        .wr_col(wr_col), .wr_data(wr_data), .wr_err(c_wr_err), .init_done(c_init_done), .lcd_e(c_lcd_e),
        .lcd_rs(c_lcd_rs), .lcd_rw(c_lcd_rw), .lcd_data(c_lcd_data), .lcd_cs(c_lcd_cs), .lcd_reset(c_lcd_reset));

    // bus monitors
    logic [1:0] mon_cs   [0:255];
    logic       mon_rs   [0:255];
    logic [7:0] mon_data [0:255];
    int         mon_dur  [0:255];
    int         mon_n = 0, dur_n = 0, run = 0, e_viol = 0;
    logic       prev_e = 1'b0;

    always @(negedge clk) begin
        prev_e <= lcd_e;
        if (lcd_e && !prev_e && mon_n < 256) begin
            mon_cs[mon_n]   <= lcd_cs;
            mon_rs[mon_n]   <= lcd_rs;
            mon_data[mon_n] <= lcd_data;
            mon_n           <= mon_n + 1;
        end
        if (lcd_e && lcd_cs == 2'b00)
            e_viol <= e_viol + 1;
        if (lcd_cs != 2'b00) begin
            run <= run + 1;
        end else if (run != 0) begin
            if (dur_n < 256) mon_dur[dur_n] <= run;
            dur_n <= dur_n + 1;
            run   <= 0;
        end
    end

    int          c_cmd_cnt = 0, c_data_cnt = 0;
    logic        c_prev_e = 1'b0;
    logic [10:0] c_last = '0;

    always @(negedge clk) begin
        c_prev_e <= c_lcd_e;
        if (c_lcd_e && !c_prev_e) begin
            c_cmd_cnt <= c_cmd_cnt + 1;
            if (c_lcd_rs && c_lcd_data == 8'h00)
                c_data_cnt <= c_data_cnt + 1;
            c_last <= {c_lcd_cs, c_lcd_rs, c_lcd_data};
        end
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]      page;
        logic [6:0]      col;
        logic [7:0]      data;
        logic [1:0]      n;
        logic [1:0]      cs;
        logic [2:0][8:0] cmd;   // {rs, byte}
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d,
                                 input logic [1:0] n, input logic [1:0] cs,
                                 input logic [8:0] c0, input logic [8:0] c1, input logic [8:0] c2);
        vec_t v;
        v.page = p; v.col = c; v.data = d; v.n = n; v.cs = cs;
        v.cmd[0] = c0; v.cmd[1] = c1; v.cmd[2] = c2;
        return v;
    endfunction

    task automatic do_write(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        wr_page = p; wr_col = c; wr_data = d; wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        lat = 0;
        while (!lcd_e && lat < 100) begin @(posedge clk); #1; lat++; end
        n = 0;
        while (!wr_ready && n < 1000) begin @(posedge clk); #1; n++; end
        check("ready_back", int'(wr_ready), 1);
        @(negedge clk); @(negedge clk);
    endtask

    task automatic wait_reset_low(input logic which, input string name);
        int n;
        n = 0;
        while (!(which ? c_lcd_reset : lcd_reset) && n < 100) begin @(posedge clk); #1; n++; end
        check(name, n, 4);
    endtask

    vec_t vecs [8];

    initial begin
        int n, lat, b, db, got, base, cbase;

        rst_n = 1'b0; rst_n_c = 1'b0;
        wr_valid = 1'b0; wr_page = '0; wr_col = '0; wr_data = '0;
        ev = 1'b0; epage = '0; ecol = '0; cv = 1'b0;

        vecs[0] = mkv(3'd3,  7'd70, 8'hA5, 2'd3, 2'b10, 9'h0BB, 9'h046, 9'h1A5);
        vecs[1] = mkv(3'd3,  7'd71, 8'h3C, 2'd1, 2'b10, 9'h13C, 9'h000, 9'h000);
        vecs[2] = mkv(3'd3,  7'd71, 8'h5A, 2'd2, 2'b10, 9'h047, 9'h15A, 9'h000);
        vecs[3] = mkv(3'd0,  7'd63, 8'h11, 2'd3, 2'b01, 9'h0B8, 9'h07F, 9'h111);
        vecs[4] = mkv(3'd0,  7'd0,  8'h22, 2'd1, 2'b01, 9'h122, 9'h000, 9'h000);
        vecs[5] = mkv(3'd5,  7'd1,  8'h33, 2'd2, 2'b01, 9'h0BD, 9'h133, 9'h000);
        vecs[6] = mkv(3'd5,  7'd127,8'h44, 2'd3, 2'b10, 9'h0BD, 9'h07F, 9'h144);
        vecs[7] = mkv(3'd5,  7'd64, 8'h55, 2'd1, 2'b10, 9'h155, 9'h000, 9'h000);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({lcd_e, lcd_rs, lcd_rw, lcd_data, lcd_cs, lcd_reset,
                                     wr_ready, wr_err, init_done}), 0);

        // power-up and init on the main DUT
        @(negedge clk); rst_n = 1'b1;
        wait_reset_low(1'b0, "pwrup_low_clks");
        n = 0;
        while (!init_done && n < 2000) begin @(posedge clk); #1; n++; end
        check("init_done", int'(init_done), 1);
        check("init_ready", int'(wr_ready), 1);
        @(negedge clk); @(negedge clk);
        check("init_ncmds", mon_n, 4);
        if (mon_n >= 4) begin
            check("init0", int'({mon_cs[0], mon_rs[0], mon_data[0]}), int'({2'b01, 1'b0, 8'h3F}));
            check("init1", int'({mon_cs[1], mon_rs[1], mon_data[1]}), int'({2'b01, 1'b0, 8'hC0}));
            check("init2", int'({mon_cs[2], mon_rs[2], mon_data[2]}), int'({2'b10, 1'b0, 8'h3F}));
            check("init3", int'({mon_cs[3], mon_rs[3], mon_data[3]}), int'({2'b10, 1'b0, 8'hC0}));
            check("init_dur", mon_dur[3], 5);
        end

        // table-driven writes through the address cache
        for (int i = 0; i < 8; i++) begin
            b = mon_n; db = dur_n;
            do_write(vecs[i].page, vecs[i].col, vecs[i].data, lat);
            check($sformatf("v%0d_latency", i), lat, 2);
            got = mon_n - b;
            check($sformatf("v%0d_ncycles", i), got, int'(vecs[i].n));
            for (int j = 0; j < int'(vecs[i].n) && j < got; j++) begin
                check($sformatf("v%0d_cmd%0d", i, j), int'({mon_rs[b+j], mon_data[b+j]}), int'(vecs[i].cmd[j]));
                check($sformatf("v%0d_cs%0d", i, j), int'(mon_cs[b+j]), int'(vecs[i].cs));
                check($sformatf("v%0d_dur%0d", i, j), mon_dur[db+j], 5);
            end
        end
        check("e_high_without_cs", e_viol, 0);

        // out-of-range requests on the 3-chip / 6-page instance
        n = 0;
        while (!e_init_done && n < 2000) begin @(posedge clk); #1; n++; end
        check("err_init_done", int'(e_init_done), 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            epage = (k == 0) ? 3'd0 : 3'd7;
            ecol  = (k == 0) ? 8'd200 : 8'd5;
            ev = 1'b1;
            @(posedge clk); #1;
            ev = 1'b0;
            check($sformatf("err%0d_pulse", k), int'({e_wr_err, e_wr_ready, e_lcd_cs}), int'({1'b1, 1'b0, 3'b000}));
            @(posedge clk); #1;
            check($sformatf("err%0d_after", k), int'({e_wr_err, e_wr_ready, e_lcd_cs}), int'({1'b0, 1'b1, 3'b000}));
        end
        @(negedge clk);
        epage = 3'd1; ecol = 8'd130; ev = 1'b1;
        @(posedge clk); #1;
        ev = 1'b0;
        check("err_valid_noerr", int'(e_wr_err), 0);
        lat = 0;
        while (!e_lcd_e && lat < 100) begin @(posedge clk); #1; lat++; end
        check("err_valid_latency", lat, 2);
        check("err_valid_bus", int'({e_lcd_cs, e_lcd_rs, e_lcd_data}), int'({3'b100, 1'b0, 8'hB9}));

        // clear-on-init instance: full clear, then cached write
        @(negedge clk); rst_n_c = 1'b1;
        cbase = c_data_cnt; base = c_cmd_cnt;
        n = 0;
        while (!c_init_done && n < 20000) begin @(posedge clk); #1; n++; end
        @(negedge clk); @(negedge clk);
        check("clr_data_cycles", c_data_cnt - cbase, 2 * 8 * 64);
        check("clr_all_cycles", c_cmd_cnt - base, 4 + 2 * 8 * 2 + 2 * 8 * 64);
        base = c_cmd_cnt;
        @(negedge clk);
        wr_page = 3'd7; wr_col = 7'd0; wr_data = 8'h99; cv = 1'b1;
        @(posedge clk); #1;
        cv = 1'b0;
        n = 0;
        while (!c_wr_ready && n < 1000) begin @(posedge clk); #1; n++; end
        @(negedge clk); @(negedge clk);
        check("clr_cached_ncycles", c_cmd_cnt - base, 1);
        check("clr_cached_bus", int'(c_last), int'({2'b01, 1'b1, 8'h99}));

        // reset asserted in the middle of a clear bus cycle
        @(negedge clk); rst_n_c = 1'b0;
        @(negedge clk); rst_n_c = 1'b1;
        cbase = c_data_cnt;
        n = 0;
        while ((c_data_cnt - cbase < 100 || !c_lcd_e) && n < 20000) begin @(posedge clk); #1; n++; end
        @(posedge clk); #2;
        rst_n_c = 1'b0;
        #1;
        check("midclear_reset", int'({c_lcd_e, c_lcd_rs, c_lcd_rw, c_lcd_data, c_lcd_cs, c_lcd_reset,
                                      c_wr_ready, c_wr_err, c_init_done}), 0);
        @(negedge clk); rst_n_c = 1'b1;
        wait_reset_low(1'b1, "restart_pwrup_low_clks");
        base = c_cmd_cnt;
        n = 0;
        while (c_cmd_cnt == base && n < 1000) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        check("restart_first_cmd", int'(c_last), int'({2'b01, 1'b0, 8'h3F}));
        cbase = c_data_cnt;
        n = 0;
        while (!c_init_done && n < 20000) begin @(posedge clk); #1; n++; end
        @(negedge clk); @(negedge clk);
        check("restart_clear_cycles", c_data_cnt - cbase, 2 * 8 * 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
